// File: rtl/muldiv_ctrl.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and restoring divider.
// The HI/LO results are registered and held until the next valid completion.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        hi_w,
    output logic        lo_w,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [2:0]  dbg_state_o
);

    // Handshake: start is taken only in IDLE (operands sampled on that edge);
    // the result is reported by a single-cycle done pulse, and start seen in
    // any other state is dropped.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] p_q, p_d;
    logic [31:0] m_q, m_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [31:0] abs_a, abs_b;
    logic [32:0] booth_sum;
    logic [64:0] booth_next;
    logic [32:0] div_shift, div_diff;
    logic [31:0] div_rem, div_quo;
    logic [64:0] div_next;

    assign abs_a = a_in[31] ? (32'd0 - a_in) : a_in;
    assign abs_b = b_in[31] ? (32'd0 - b_in) : b_in;

    // Booth add is done at 33 bits so the shifted-in sign stays correct
    // when the multiplicand is 0x80000000.
    always_comb begin
        booth_sum = {p_q[64], p_q[64:33]};
        case (p_q[1:0])
            2'b01:   booth_sum = {p_q[64], p_q[64:33]} + {m_q[31], m_q};
            2'b10:   booth_sum = {p_q[64], p_q[64:33]} - {m_q[31], m_q};
            default: booth_sum = {p_q[64], p_q[64:33]};
        endcase
        booth_next = {booth_sum, p_q[32:1]};
    end

    // Divide layout reuses the product register: {remainder, quotient, spare}.
    always_comb begin
        div_shift = {p_q[64:33], p_q[32]};
        div_diff  = div_shift - {1'b0, m_q};
        if (!div_diff[32]) begin
            div_rem = div_diff[31:0];
            div_quo = {p_q[31:1], 1'b1};
        end else begin
            div_rem = div_shift[31:0];
            div_quo = {p_q[31:1], 1'b0};
        end
        div_next = {div_rem, div_quo, 1'b0};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = 6'd0;
                    dz_d  = 1'b0;
                    if (!op) begin
                        p_d     = {32'd0, b_in, 1'b0};
                        m_d     = a_in;
                        state_d = S_MULT;
                    end else if (b_in == 32'd0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        p_d     = {32'd0, abs_a, 1'b0};
                        m_d     = abs_b;
                        sa_d    = a_in[31];
                        sb_d    = b_in[31];
                        state_d = S_DIV;
                    end
                end
            end
            S_MULT: begin
                p_d   = booth_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    hi_d    = booth_next[64:33];
                    lo_d    = booth_next[32:1];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                p_d   = div_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = sa_q ? (32'd0 - p_q[64:33]) : p_q[64:33];
                lo_d    = (sa_q ^ sb_q) ? (32'd0 - p_q[32:1]) : p_q[32:1];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            p_q     <= 65'd0;
            m_q     <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy        = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign div_zero    = done && dz_q;
    assign hi_w        = done && !dz_q;
    assign lo_w        = done && !dz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        hi_w;
    logic        lo_w;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [2:0]  dbg_state;

    muldiv_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi_w        (hi_w),
        .lo_w        (lo_w),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;
    logic [31:0] specials [6] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000001,
                                  32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: signed 64-bit arithmetic, truncating division.
    function automatic void ref_op(input logic op_v, input logic [31:0] a, input logic [31:0] b,
                                   output logic [63:0] res, output logic dz);
        longint sa, sb, q, r, p;
        dz  = 1'b0;
        res = 64'd0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (!op_v) begin
            p   = sa * sb;
            res = p;
        end else if (b == 32'd0) begin
            dz = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
    endfunction

    task automatic drive_junk();
        op   = 1'($urandom_range(0, 1));
        a_in = $urandom;
        b_in = $urandom;
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic op_v, input logic [31:0] a, input logic [31:0] b,
                          input int poke_cyc, input bit start_in_done);
        logic [63:0] res;
        logic [63:0] exp_v;
        logic        dz;
        int          cyc;
        int          lat;
        ref_op(op_v, a, b, res, dz);
        lat = dz ? 1 : (op_v ? 34 : 33);
        if (!dz) exp_q.push_back(res);
        else     exp_q.push_back({mdl_hi, mdl_lo});
        @(negedge clk);
        start = 1'b1;
        op    = op_v;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        drive_junk();
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            check_val("busy_run", 64'(busy), 64'd1);
            check_val("flags_quiet", 64'({div_zero, hi_w, lo_w}), 64'd0);
            start = (cyc == poke_cyc);
            drive_junk();
            @(negedge clk);
            cyc++;
        end
        start = start_in_done;
        drive_junk();
        check_val("done", 64'(done), 64'd1);
        check_val("latency", 64'(cyc), 64'(lat));
        exp_v = exp_q.pop_front();
        check_val("div_zero", 64'(div_zero), 64'(dz));
        check_val("hi_w", 64'(hi_w), 64'(!dz));
        check_val("lo_w", 64'(lo_w), 64'(!dz));
        check_val("result", {hi_out, lo_out}, exp_v);
        check_val("busy_done", 64'(busy), 64'd0);
        if (!dz) {mdl_hi, mdl_lo} = res;
        @(negedge clk);
        start = 1'b0;
        check_val("idle_after", 64'({busy, done, div_zero, hi_w, lo_w}), 64'd0);
        check_val("held", {hi_out, lo_out}, {mdl_hi, mdl_lo});
    endtask

    // Start a divide and reset it part-way through.
    task automatic reset_mid(input int at_cyc);
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        a_in  = 32'd17;
        b_in  = 32'hFFFFFFFB;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < at_cyc; c++) begin
            check_val("busy_pre_rst", 64'(busy), 64'd1);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        check_val("rst_flags", 64'({busy, done, div_zero, hi_w, lo_w}), 64'd0);
        check_val("rst_result", {hi_out, lo_out}, 64'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_val("no_done_after_rst", 64'({busy, done, hi_w, lo_w}), 64'd0);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        logic        rop;
        logic [31:0] ra, rb;
        int          poke;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("reset_flags", 64'({busy, done, div_zero, hi_w, lo_w}), 64'd0);
        check_val("reset_result", {hi_out, lo_out}, 64'd0);

        run_op(1'b0, 32'd7, 32'hFFFFFFFD, -1, 1'b0);
        run_op(1'b0, 32'h80000000, 32'h80000000, -1, 1'b1);
        run_op(1'b1, 32'd17, 32'hFFFFFFFB, -1, 1'b0);
        run_op(1'b1, 32'hFFFFFFEF, 32'd5, -1, 1'b0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, -1, 1'b0);
        run_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 10, 1'b0);
        reset_mid(20);
        run_op(1'b0, 32'hDEADBEEF, 32'h00C0FFEE, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = specials[$urandom_range(0, 5)];
                2: ra = specials[$urandom_range(0, 5)];
                default: ;
            endcase
            poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : -1;
            run_op(rop, ra, rb, poke, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
